// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: history-counter encodings,
// prediction modes and the saturating counter step.
package bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] BP_WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] BP_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] BP_ST  = 2'b11;  // strongly taken

    localparam int BP_MODE_BTB     = 0;
    localparam int BP_MODE_BIMODAL = 1;

    // Saturating 2-bit history step: toward BP_ST on taken, toward BP_SNT otherwise.
    function automatic logic [1:0] bp_cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BP_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: combinational lookup read port plus a
// read-modify-write update port (the addressed entry is exposed so the
// caller can decide hit/miss and the next counter value).
module btb_table
    import bp_pkg::*;
#(
    parameter int ENTRY_NUM = 64,
    parameter int IDX_W     = $clog2(ENTRY_NUM),
    parameter int TAG_W     = 30 - IDX_W,
    parameter bit HAS_CNT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    // lookup read port
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_target,
    output logic [1:0]       rd_cnt,
    // update port: current contents of the addressed entry, then the write
    input  logic [IDX_W-1:0] wr_idx,
    output logic             wr_cur_valid,
    output logic [TAG_W-1:0] wr_cur_tag,
    output logic [1:0]       wr_cur_cnt,
    input  logic             wr_en,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [1:0]       wr_cnt,
    input  logic             wr_tgt_en,
    input  logic [31:0]      wr_target
);

    logic [ENTRY_NUM-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q    [ENTRY_NUM];
    logic [TAG_W-1:0]     tag_d    [ENTRY_NUM];
    logic [31:0]          target_q [ENTRY_NUM];
    logic [31:0]          target_d [ENTRY_NUM];

    assign rd_valid     = valid_q[rd_idx];
    assign rd_tag       = tag_q[rd_idx];
    assign rd_target    = target_q[rd_idx];
    assign wr_cur_valid = valid_q[wr_idx];
    assign wr_cur_tag   = tag_q[wr_idx];

    // Next-state of valid/tag/target: only the addressed entry changes.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
            tag_d[wr_idx]   = wr_tag;
        end
        if (wr_tgt_en) target_d[wr_idx] = wr_target;
    end

    // Valid bits are control state; reset clears them and drops any write.
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag and target are data; a cleared valid bit makes them don't-care.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    if (HAS_CNT) begin : g_cnt
        logic [1:0] cnt_q [ENTRY_NUM];
        logic [1:0] cnt_d [ENTRY_NUM];

        assign rd_cnt     = cnt_q[rd_idx];
        assign wr_cur_cnt = cnt_q[wr_idx];

        // Next-state of the history counters.
        always_comb begin
            cnt_d = cnt_q;
            if (wr_en) cnt_d[wr_idx] = wr_cnt;
        end

        // History counters restart weakly not-taken on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < ENTRY_NUM; i++) cnt_q[i] <= BP_WNT;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end else begin : g_no_cnt
        logic unused_wr_cnt;
        assign unused_wr_cnt = ^wr_cnt;
        assign rd_cnt        = BP_WNT;
        assign wr_cur_cnt    = BP_WNT;
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Branch prediction unit: BTB (optionally with bimodal counters) looked up
// combinationally from IF, updated by resolved branches from EX, plus
// saturating branch / misprediction performance counters.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int ENTRY_NUM = 64,
    parameter int MODE      = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      lookup_pc,
    output logic             predict_taken,
    output logic [31:0]      predict_target,
    input  logic             update_valid,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             update_mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W   = $clog2(ENTRY_NUM);
    localparam int TAG_W   = 30 - IDX_W;
    localparam bit HAS_CNT = (MODE == BP_MODE_BIMODAL);

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_valid, up_valid;
    logic [TAG_W-1:0] lk_tag_rd, up_tag_rd;
    logic [31:0]      lk_target;
    logic [1:0]       lk_cnt, up_cnt;
    logic             lk_hit, up_hit;
    logic             wr_en, wr_valid, wr_tgt_en;
    logic [1:0]       wr_cnt;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic             unused_pc_lsbs;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[31:IDX_W+2];
    assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

    btb_table #(
        .ENTRY_NUM (ENTRY_NUM),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .HAS_CNT   (HAS_CNT)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (lk_idx),
        .rd_valid     (lk_valid),
        .rd_tag       (lk_tag_rd),
        .rd_target    (lk_target),
        .rd_cnt       (lk_cnt),
        .wr_idx       (up_idx),
        .wr_cur_valid (up_valid),
        .wr_cur_tag   (up_tag_rd),
        .wr_cur_cnt   (up_cnt),
        .wr_en        (wr_en),
        .wr_valid     (wr_valid),
        .wr_tag       (up_tag),
        .wr_cnt       (wr_cnt),
        .wr_tgt_en    (wr_tgt_en),
        .wr_target    (update_target)
    );

    // IF lookup: hit test and prediction, no bypass from a same-cycle update.
    always_comb begin
        lk_hit         = lk_valid && (lk_tag_rd == lk_tag);
        predict_taken  = lk_hit && ((MODE == BP_MODE_BTB) ? 1'b1 : lk_cnt[1]);
        predict_target = predict_taken ? lk_target : lookup_pc + 32'd4;
    end

    // EX update policy: allocate on taken miss, train or invalidate on hit.
    always_comb begin
        up_hit    = up_valid && (up_tag_rd == up_tag);
        wr_en     = 1'b0;
        wr_valid  = 1'b0;
        wr_tgt_en = 1'b0;
        wr_cnt    = BP_WT;
        if (update_valid) begin
            if (!up_hit) begin
                if (update_taken) begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tgt_en = 1'b1;
                    wr_cnt    = BP_WT;
                end
            end else if (MODE == BP_MODE_BIMODAL) begin
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tgt_en = update_taken;
                wr_cnt    = bp_cnt_next(up_cnt, update_taken);
            end else begin
                wr_en     = 1'b1;
                wr_valid  = update_taken;
                wr_tgt_en = update_taken;
                wr_cnt    = up_cnt;
            end
        end
    end

    // Performance counters saturate at all-ones instead of wrapping.
    always_comb begin
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (update_valid) begin
            if (br_count_q != {CNT_W{1'b1}}) br_count_d = br_count_q + CNT_W'(1);
            if (update_mispredict && (miss_count_q != {CNT_W{1'b1}}))
                miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    // Counter registers; reset takes priority over a coincident update.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign br_count   = br_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: three configurations share one stimulus
// stream; a behavioural table model checks every cycle, directed literals pin it.
module tb_branch_predictor_btb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] lookup_pc, update_pc, update_target;
    logic        update_valid, update_taken, update_mispredict;

    logic        pt0, pt1, pt2;
    logic [31:0] tg0, tg1, tg2;
    logic [31:0] br0, ms0, br1, ms1;
    logic [3:0]  br2, ms2;

    branch_predictor_btb #(.ENTRY_NUM(64), .MODE(1), .CNT_W(32)) u_d0 (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(pt0), .predict_target(tg0),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .br_count(br0), .miss_count(ms0));

    branch_predictor_btb #(.ENTRY_NUM(64), .MODE(0), .CNT_W(32)) u_d1 (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(pt1), .predict_target(tg1),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .br_count(br1), .miss_count(ms1));

    branch_predictor_btb #(.ENTRY_NUM(16), .MODE(1), .CNT_W(4)) u_d2 (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(pt2), .predict_target(tg2),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .br_count(br2), .miss_count(ms2));

    logic        pt  [3];
    logic [31:0] tg  [3];
    logic [63:0] brc [3];
    logic [63:0] msc [3];
    assign pt[0] = pt0;  assign pt[1] = pt1;  assign pt[2] = pt2;
    assign tg[0] = tg0;  assign tg[1] = tg1;  assign tg[2] = tg2;
    assign brc[0] = {32'd0, br0}; assign brc[1] = {32'd0, br1}; assign brc[2] = {60'd0, br2};
    assign msc[0] = {32'd0, ms0}; assign msc[1] = {32'd0, ms1}; assign msc[2] = {60'd0, ms2};

    // Model configuration and state: entries, mode, counter ceiling per instance.
    int              ents [3] = '{64, 64, 16};
    int              mmode[3] = '{1, 0, 1};
    longint unsigned cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};
    bit              mv   [3][1024];
    longint unsigned mtag [3][1024];
    logic [31:0]     mtgt [3][1024];
    int              mcnt [3][1024];
    longint unsigned mbr  [3];
    longint unsigned mms  [3];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advances on each rising edge from the inputs presented that cycle.
    int              m_idx;
    longint unsigned m_tag;
    bit              m_hit;
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                for (int i = 0; i < 1024; i++) begin
                    mv[d][i]   = 1'b0;
                    mcnt[d][i] = 1;
                end
                mbr[d] = 0;
                mms[d] = 0;
            end else if (update_valid) begin
                m_idx = int'((longint'(update_pc) >> 2) % ents[d]);
                m_tag = longint'(update_pc) / (4 * ents[d]);
                if (mbr[d] < cmax[d]) mbr[d] = mbr[d] + 1;
                if (update_mispredict && mms[d] < cmax[d]) mms[d] = mms[d] + 1;
                m_hit = mv[d][m_idx] && (mtag[d][m_idx] == m_tag);
                if (!m_hit) begin
                    if (update_taken) begin
                        mv[d][m_idx]   = 1'b1;
                        mtag[d][m_idx] = m_tag;
                        mtgt[d][m_idx] = update_target;
                        mcnt[d][m_idx] = 2;
                    end
                end else if (mmode[d] == 1) begin
                    if (update_taken) begin
                        mcnt[d][m_idx] = (mcnt[d][m_idx] >= 3) ? 3 : mcnt[d][m_idx] + 1;
                        mtgt[d][m_idx] = update_target;
                    end else begin
                        mcnt[d][m_idx] = (mcnt[d][m_idx] <= 0) ? 0 : mcnt[d][m_idx] - 1;
                    end
                end else begin
                    if (update_taken) mtgt[d][m_idx] = update_target;
                    else              mv[d][m_idx]   = 1'b0;
                end
            end
        end
    end

    // Every cycle, away from the edge: all outputs of all instances against the model.
    int              c_idx;
    longint unsigned c_tag;
    bit              c_taken;
    logic [31:0]     c_tgt;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                c_idx   = int'((longint'(lookup_pc) >> 2) % ents[d]);
                c_tag   = longint'(lookup_pc) / (4 * ents[d]);
                c_taken = mv[d][c_idx] && (mtag[d][c_idx] == c_tag) &&
                          (mmode[d] == 0 || mcnt[d][c_idx] >= 2);
                c_tgt   = c_taken ? mtgt[d][c_idx] : lookup_pc + 32'd4;
                chk($sformatf("model_taken[%0d]", d), {63'd0, pt[d]}, {63'd0, c_taken});
                chk($sformatf("model_target[%0d]", d), {32'd0, tg[d]}, {32'd0, c_tgt});
                chk($sformatf("model_br[%0d]", d), brc[d], mbr[d]);
                chk($sformatf("model_miss[%0d]", d), msc[d], mms[d]);
            end
        end
    end

    task automatic drv(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic tk, input logic [31:0] tgt, input logic mp);
        lookup_pc         = lpc;
        update_valid      = uv;
        update_pc         = upc;
        update_taken      = tk;
        update_target     = tgt;
        update_mispredict = mp;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drv(32'h100, 0, 0, 0, 0, 0);
        nxt();
        rst    = 1'b0;
        chk_en = 1'b1;

        // reset state
        smp();
        chk("rst_taken", pt0, 0);
        chk("rst_target", tg0, 32'h104);
        chk("rst_br", br0, 0);
        chk("rst_miss", ms0, 0);
        nxt();

        // same-cycle update and lookup sees pre-update contents
        drv(32'h100, 1, 32'h100, 1, 32'h80, 1);
        smp();
        chk("same_cycle_taken", pt0, 0);
        chk("same_cycle_target", tg0, 32'h104);
        nxt();
        drv(32'h100, 0, 0, 0, 0, 0);
        smp();
        chk("alloc_taken", pt0, 1);
        chk("alloc_target", tg0, 32'h80);
        chk("alloc_miss", ms0, 1);
        chk("alloc_br", br0, 1);
        chk("alloc_m0_target", tg1, 32'h80);
        chk("alloc_e16_taken", pt2, 1);
        nxt();

        // two not-taken updates
        drv(32'h100, 1, 32'h100, 0, 0, 1);
        nxt();
        drv(32'h100, 1, 32'h100, 0, 0, 0);
        smp();
        chk("m0_invalidated_taken", pt1, 0);
        chk("m0_invalidated_target", tg1, 32'h104);
        nxt();
        drv(32'h100, 0, 0, 0, 0, 0);
        smp();
        chk("nt2_taken", pt0, 0);
        chk("nt2_target", tg0, 32'h104);
        chk("nt2_br", br0, 3);
        chk("nt2_miss", ms0, 2);
        nxt();

        // three taken then one not-taken: counter ends at weak-taken
        for (int i = 0; i < 3; i++) begin
            drv(32'h100, 1, 32'h100, 1, 32'h90, 0);
            nxt();
        end
        drv(32'h100, 1, 32'h100, 0, 0, 0);
        nxt();
        drv(32'h100, 0, 0, 0, 0, 0);
        smp();
        chk("ttt_n_taken", pt0, 1);
        chk("ttt_n_target", tg0, 32'h90);
        chk("ttt_n_m0_taken", pt1, 0);
        nxt();

        // alias: 0x200 shares index 0 with 0x100
        drv(32'h100, 1, 32'h200, 1, 32'h300, 1);
        nxt();
        drv(32'h100, 0, 0, 0, 0, 0);
        smp();
        chk("alias_old_taken", pt0, 0);
        chk("alias_old_target", tg0, 32'h104);
        nxt();
        drv(32'h200, 0, 0, 0, 0, 0);
        smp();
        chk("alias_new_taken", pt0, 1);
        chk("alias_new_target", tg0, 32'h300);
        chk("alias_e16_target", tg2, 32'h300);
        nxt();

        // BTB-only: allocate then invalidate 0x40
        drv(32'h40, 1, 32'h40, 1, 32'h1000, 1);
        nxt();
        drv(32'h40, 0, 0, 0, 0, 0);
        smp();
        chk("m0_alloc_taken", pt1, 1);
        chk("m0_alloc_target", tg1, 32'h1000);
        nxt();
        drv(32'h40, 1, 32'h40, 0, 0, 1);
        nxt();
        drv(32'h40, 0, 0, 0, 0, 0);
        smp();
        chk("m0_clear_taken", pt1, 0);
        chk("m0_clear_target", tg1, 32'h44);
        chk("m1_weak_nt_taken", pt0, 0);
        nxt();

        // fall-through wraps; mispredict without valid is ignored
        drv(32'hFFFF_FFFC, 0, 0, 0, 0, 1);
        smp();
        chk("wrap_target", tg0, 32'h0);
        nxt();
        drv(32'h100, 0, 0, 0, 0, 0);
        smp();
        chk("ignored_mp_miss", ms0, 5);
        chk("ignored_mp_br", br0, 10);
        nxt();

        // counter saturation in the 4-bit instance
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drv(32'h500, 1, 32'h500, 0, 0, 1);
            nxt();
        end
        drv(32'h500, 0, 0, 0, 0, 0);
        smp();
        chk("sat_br4", br2, 15);
        chk("sat_miss4", ms2, 15);
        chk("sat_br32", br0, 20);
        chk("sat_miss32", ms0, 20);
        nxt();

        // reset wins over a coincident update
        rst = 1'b1;
        drv(32'h100, 1, 32'h100, 1, 32'h80, 1);
        nxt();
        rst = 1'b0;
        drv(32'h100, 0, 0, 0, 0, 0);
        smp();
        chk("rst_upd_taken", pt0, 0);
        chk("rst_upd_target", tg0, 32'h104);
        chk("rst_upd_br", br0, 0);
        chk("rst_upd_miss", ms2, 0);
        chk("rst_upd_m0_taken", pt1, 0);
        nxt();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
